// File: rtl/seq_alu_accel.sv
// Memory-mapped sequential ALU: W-bit operands, 2W-bit result, start/busy/done handshake,
// single-cycle logic/shift/compare plus W-step shift-add multiply/MAC and restoring divide.
module seq_alu_accel #(
  parameter int W = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] ui_in,
  output logic [7:0] uo_out,
  input  logic [3:0] address,
  input  logic       data_write,
  input  logic [7:0] data_in,
  output logic [7:0] data_out
);
  localparam int LW = $clog2(W);
  localparam int RW = 2 * W;
  localparam logic [LW:0] WL = (LW + 1)'(W);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_RUN  = 1'b1;

  localparam logic [3:0] OP_ADD = 4'd0, OP_SUB = 4'd1, OP_AND = 4'd2, OP_OR  = 4'd3;
  localparam logic [3:0] OP_XOR = 4'd4, OP_SHL = 4'd5, OP_SHR = 4'd6, OP_MUL = 4'd7;
  localparam logic [3:0] OP_MAC = 4'd8, OP_DIV = 4'd9, OP_CMP = 4'd10;

  logic [0:0]    state_q, state_d;
  logic [3:0]    op_q, op_d;
  logic [W-1:0]  a_q, a_d, b_q, b_d, q_q, q_d, rm_q, rm_d, db_q, db_d;
  logic [RW-1:0] r_q, r_d, p_q, p_d, m_q, m_d;
  logic [LW:0]   cnt_q, cnt_d;
  logic done_q, done_d, zero_q, zero_d, carry_q, carry_d;
  logic divz_q, divz_d, ill_q, ill_d, ovr_q, ovr_d;

  logic unused_ui;
  assign unused_ui = ^ui_in;

  // Single-cycle datapath, keyed by the opcode being written to CTRL
  logic [W:0]    ext;
  logic [W-1:0]  sc_res;
  logic [LW:0]   sh;
  always_comb begin
    sh     = b_q[LW:0];
    ext    = '0;
    sc_res = '0;
    case (data_in[3:0])
      OP_ADD: begin ext = {1'b0, a_q} + {1'b0, b_q}; sc_res = ext[W-1:0]; end
      OP_SUB: begin ext = {1'b0, a_q} - {1'b0, b_q}; sc_res = ext[W-1:0]; end
      OP_AND: sc_res = a_q & b_q;
      OP_OR:  sc_res = a_q | b_q;
      OP_XOR: sc_res = a_q ^ b_q;
      OP_SHL: sc_res = (sh >= WL) ? '0 : a_q << sh;
      OP_SHR: sc_res = (sh >= WL) ? '0 : a_q >> sh;
      default: sc_res = '0;
    endcase
  end

  // One iteration of shift-add multiply and restoring divide
  logic [RW-1:0] p_step;
  logic [W:0]    rsh, rsub;
  logic          ge;
  logic [W-1:0]  rm_step, q_div;
  logic [RW:0]   mac_sum;
  always_comb begin
    p_step  = p_q + (q_q[0] ? m_q : '0);
    rsh     = {rm_q, q_q[W-1]};
    ge      = rsh >= {1'b0, db_q};
    rsub    = rsh - {1'b0, db_q};
    rm_step = ge ? rsub[W-1:0] : rsh[W-1:0];
    q_div   = {q_q[W-2:0], ge};
    mac_sum = {1'b0, r_q} + {1'b0, p_step};
  end

  logic [RW-1:0] rn;
  always_comb begin
    state_d = state_q; op_d = op_q; a_d = a_q; b_d = b_q; r_d = r_q;
    p_d = p_q; m_d = m_q; q_d = q_q; rm_d = rm_q; db_d = db_q; cnt_d = cnt_q;
    done_d = done_q; zero_d = zero_q; carry_d = carry_q;
    divz_d = divz_q; ill_d = ill_q; ovr_d = ovr_q;
    rn = '0;

    if (data_write && address == 4'h5) begin
      done_d  = done_q  & ~data_in[1];
      zero_d  = zero_q  & ~data_in[2];
      carry_d = carry_q & ~data_in[3];
      divz_d  = divz_q  & ~data_in[4];
      ill_d   = ill_q   & ~data_in[5];
      ovr_d   = ovr_q   & ~data_in[6];
    end

    if (state_q == S_IDLE) begin
      // Hi-byte writes vanish by truncation when W=8
      if (data_write) begin
        case (address)
          4'h0: a_d = (a_q & ~W'(8'hFF)) | W'(data_in);
          4'h1: a_d = (a_q & ~(W'(8'hFF) << 8)) | (W'(data_in) << 8);
          4'h2: b_d = (b_q & ~W'(8'hFF)) | W'(data_in);
          4'h3: b_d = (b_q & ~(W'(8'hFF) << 8)) | (W'(data_in) << 8);
          4'h4: op_d = data_in[3:0];
          default: ;
        endcase
      end
      if (data_write && address == 4'h4 && data_in[7]) begin
        done_d = 1'b0;
        case (data_in[3:0])
          OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_SHL, OP_SHR: begin
            r_d     = RW'(sc_res);
            carry_d = (data_in[3:0] == OP_ADD || data_in[3:0] == OP_SUB) ? ext[W] : 1'b0;
            zero_d  = (sc_res == '0);
            done_d  = 1'b1;
          end
          OP_CMP: begin
            zero_d  = (a_q == b_q);
            carry_d = (a_q < b_q);
            done_d  = 1'b1;
          end
          OP_MUL, OP_MAC: begin
            p_d = '0; m_d = RW'(a_q); q_d = b_q; cnt_d = WL; state_d = S_RUN;
          end
          OP_DIV: begin
            if (b_q == '0) begin
              r_d = {a_q, {W{1'b1}}};
              divz_d = 1'b1; carry_d = 1'b0; zero_d = 1'b0; done_d = 1'b1;
            end else begin
              rm_d = '0; q_d = a_q; db_d = b_q; cnt_d = WL; state_d = S_RUN;
            end
          end
          default: begin
            ill_d  = 1'b1;
            done_d = 1'b1;
          end
        endcase
      end
    end else begin
      if (data_write && address <= 4'h4) ovr_d = 1'b1;
      cnt_d = cnt_q - 1'b1;
      if (op_q == OP_DIV) begin
        rm_d = rm_step; q_d = q_div;
      end else begin
        p_d = p_step; m_d = m_q << 1; q_d = q_q >> 1;
      end
      // Last step: commit after any same-edge W1C so completion wins
      if (cnt_q == (LW + 1)'(1)) begin
        carry_d = 1'b0;
        case (op_q)
          OP_MAC: begin rn = mac_sum[RW-1:0]; carry_d = mac_sum[RW]; end
          OP_DIV: rn = {rm_step, q_div};
          default: rn = p_step;
        endcase
        r_d     = rn;
        zero_d  = (rn == '0);
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE; op_q <= '0; a_q <= '0; b_q <= '0; r_q <= '0;
      p_q <= '0; m_q <= '0; q_q <= '0; rm_q <= '0; db_q <= '0; cnt_q <= '0;
      done_q <= 1'b0; zero_q <= 1'b0; carry_q <= 1'b0;
      divz_q <= 1'b0; ill_q <= 1'b0; ovr_q <= 1'b0;
    end else begin
      state_q <= state_d; op_q <= op_d; a_q <= a_d; b_q <= b_d; r_q <= r_d;
      p_q <= p_d; m_q <= m_d; q_q <= q_d; rm_q <= rm_d; db_q <= db_d; cnt_q <= cnt_d;
      done_q <= done_d; zero_q <= zero_d; carry_q <= carry_d;
      divz_q <= divz_d; ill_q <= ill_d; ovr_q <= ovr_d;
    end
  end

  assign uo_out = {5'b0, done_q, state_q == S_RUN, 1'b0};

  always_comb begin
    case (address)
      4'h0: data_out = 8'(a_q);
      4'h1: data_out = 8'(a_q >> 8);
      4'h2: data_out = 8'(b_q);
      4'h3: data_out = 8'(b_q >> 8);
      4'h4: data_out = {4'b0, op_q};
      4'h5: data_out = {1'b0, ovr_q, ill_q, divz_q, carry_q, zero_q, done_q, state_q == S_RUN};
      4'h6: data_out = 8'(r_q);
      4'h7: data_out = 8'(r_q >> 8);
      4'h8: data_out = 8'(r_q >> 16);
      4'h9: data_out = 8'(r_q >> 24);
      default: data_out = 8'h00;
    endcase
  end
endmodule

// File: tb/tb_seq_alu_accel.sv
// Bench for seq_alu_accel: W=8 and W=16 instances share one bus; directed sequences,
// a vector table, and random ops checked against an arithmetic reference model.
module tb_seq_alu_accel;
  logic       clk = 1'b0, rst = 1'b1, data_write = 1'b0;
  logic [3:0] address = '0;
  logic [7:0] data_in = '0, ui_in = '0;
  logic [7:0] uo8, do8, uo16, do16;
  int tests = 0, fails = 0;

  always #10 clk = ~clk;

  seq_alu_accel #(.W(8)) u8 (.clk(clk), .rst(rst), .ui_in(ui_in), .uo_out(uo8),
    .address(address), .data_write(data_write), .data_in(data_in), .data_out(do8));
  seq_alu_accel #(.W(16)) u16 (.clk(clk), .rst(rst), .ui_in(ui_in), .uo_out(uo16),
    .address(address), .data_write(data_write), .data_in(data_in), .data_out(do16));

  typedef struct {
    logic [3:0] op; logic [7:0] a, b; logic [15:0] r; logic [7:0] st, msk;
  } vec_t;
  vec_t tbl[19];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic wr(input logic [3:0] ad, input logic [7:0] d);
    address = ad; data_in = d; data_write = 1'b1;
    @(negedge clk);
    data_write = 1'b0;
  endtask

  task automatic rd(input logic [3:0] ad, output logic [7:0] v8, output logic [7:0] v16);
    address = ad; #1;
    v8 = do8; v16 = do16;
  endtask

  task automatic rres(output logic [31:0] r8, output logic [31:0] r16);
    logic [7:0] x, y;
    r8 = '0; r16 = '0;
    for (int i = 0; i < 4; i++) begin
      rd(4'(6 + i), x, y);
      r8[8*i +: 8] = x; r16[8*i +: 8] = y;
    end
  endtask

  task automatic setab(input logic [15:0] a, input logic [15:0] b);
    wr(4'h0, a[7:0]); wr(4'h1, a[15:8]); wr(4'h2, b[7:0]); wr(4'h3, b[15:8]);
  endtask

  task automatic do_op(input logic [3:0] op);
    wr(4'h5, 8'h7E);
    wr(4'h4, 8'h80 | {4'b0, op});
  endtask

  task automatic wait_idle(output int n8, output int n16);
    n8 = 0; n16 = 0;
    for (int i = 0; i < 64 && (uo8[1] || uo16[1]); i++) begin
      if (uo8[1]) n8++;
      if (uo16[1]) n16++;
      @(negedge clk);
    end
    if (uo8[1] || uo16[1]) chk("idle_timeout", 32'd1, 32'd0);
  endtask

  task automatic pulse_rst();
    rst = 1'b1; @(negedge clk); rst = 1'b0;
  endtask

  // Reference: plain arithmetic on the operand values
  task automatic model(input int w, input logic [3:0] op, input logic [15:0] a,
                       input logic [15:0] b, input logic [31:0] rin,
                       output logic [31:0] r, output logic [7:0] st,
                       output logic [7:0] msk, output int lat);
    longint unsigned mk, fm, aa, bb, rr, s, rl, sh;
    logic z, c, dz, il;
    mk = (w == 8) ? 64'hFF : 64'hFFFF;
    fm = (w == 8) ? 64'hFFFF : 64'hFFFF_FFFF;
    aa = a & mk; bb = b & mk; rr = rin;
    sh = bb & ((w == 8) ? 64'hF : 64'h1F);
    z = 0; c = 0; dz = 0; il = 0; lat = 0; msk = 8'hFF; rl = 0;
    case (op)
      0: begin s = aa + bb; rl = s & mk; c = s > mk; end
      1: begin rl = (aa - bb) & mk; c = aa < bb; end
      2: begin rl = aa & bb; msk = 8'hF7; end
      3: begin rl = aa | bb; msk = 8'hF7; end
      4: begin rl = aa ^ bb; msk = 8'hF7; end
      5: begin rl = (sh >= w) ? 0 : (aa << sh) & mk; msk = 8'hF7; end
      6: begin rl = (sh >= w) ? 0 : aa >> sh; msk = 8'hF7; end
      7: begin rl = aa * bb; lat = w; end
      8: begin s = rr + aa * bb; rl = s & fm; c = s > fm; lat = w; end
      9: if (bb == 0) begin rl = (aa << w) | mk; dz = 1; end
         else begin rl = ((aa % bb) << w) | (aa / bb); lat = w; end
      10: begin rl = rr; z = (aa == bb); c = aa < bb; end
      default: begin rl = rr; il = 1; msk = 8'hF3; end
    endcase
    if (op < 10) z = (rl == 0);
    r = rl[31:0];
    st = {2'b0, il, dz, c, z, 1'b1, 1'b0};
  endtask

  initial begin
    logic [31:0] r8, r16, e8, e16, mr8, mr16;
    logic [7:0] s8, s16, es8, es16, m8, m16;
    logic [15:0] ra, rb;
    logic [3:0] rop;
    int n8, n16, l8, l16;

    tbl = '{
      '{4'd0, 8'hF0, 8'h20, 16'h0010, 8'h0A, 8'hFF}, '{4'd0, 8'h80, 8'h80, 16'h0000, 8'h0E, 8'hFF},
      '{4'd1, 8'h05, 8'h07, 16'h00FE, 8'h0A, 8'hFF}, '{4'd1, 8'h09, 8'h09, 16'h0000, 8'h06, 8'hFF},
      '{4'd2, 8'hF0, 8'h3C, 16'h0030, 8'h02, 8'hF7}, '{4'd3, 8'hF0, 8'h0F, 16'h00FF, 8'h02, 8'hF7},
      '{4'd4, 8'hAA, 8'hAA, 16'h0000, 8'h06, 8'hF7}, '{4'd5, 8'h81, 8'h01, 16'h0002, 8'h02, 8'hF7},
      '{4'd5, 8'h01, 8'h07, 16'h0080, 8'h02, 8'hF7}, '{4'd5, 8'hFF, 8'h08, 16'h0000, 8'h06, 8'hF7},
      '{4'd6, 8'h80, 8'h07, 16'h0001, 8'h02, 8'hF7}, '{4'd6, 8'hFF, 8'h0F, 16'h0000, 8'h06, 8'hF7},
      '{4'd6, 8'hF0, 8'h13, 16'h001E, 8'h02, 8'hF7}, '{4'd7, 8'h0F, 8'h0F, 16'h00E1, 8'h02, 8'hFF},
      '{4'd9, 8'hFF, 8'h10, 16'h0F0F, 8'h02, 8'hFF}, '{4'd10, 8'h03, 8'h05, 16'h0F0F, 8'h0A, 8'hFF},
      '{4'd10, 8'h07, 8'h07, 16'h0F0F, 8'h06, 8'hFF}, '{4'd8, 8'h02, 8'h03, 16'h0F15, 8'h02, 8'hFF},
      '{4'd8, 8'hFF, 8'hFF, 16'h0D16, 8'h0A, 8'hFF}
    };

    repeat (2) @(negedge clk);
    rst = 1'b0;
    rd(4'h5, s8, s16);
    chk("rst_status", {s8, s16}, 16'h0);
    chk("rst_uo", {uo8, uo16}, 16'h0);
    rres(r8, r16);
    chk("rst_r", r8 | r16, 32'h0);

    // SUB: single-cycle, carry = borrow
    setab(16'd5, 16'd7); wr(4'h4, 8'h81);
    chk("sub_uo", uo8, 8'h04);
    rres(r8, r16); rd(4'h5, s8, s16);
    chk("sub_r", r8, 32'h00FE);
    chk("sub_st", s8, 8'h0A);

    // MUL: busy exactly W cycles
    setab(16'd200, 16'd3); wr(4'h4, 8'h87);
    wait_idle(n8, n16);
    chk("mul_lat8", n8, 8); chk("mul_lat16", n16, 16);
    rres(r8, r16); rd(4'h5, s8, s16);
    chk("mul_r8", r8, 32'h0258); chk("mul_r16", r16, 32'h0258);
    chk("mul_st", s8, 8'h02);

    // DIV and divide-by-zero
    setab(16'd100, 16'd7); wr(4'h4, 8'h89);
    wait_idle(n8, n16); rres(r8, r16);
    chk("div_lat", n8, 8); chk("div_r", r8, 32'h020E);
    setab(16'd100, 16'd0); wr(4'h4, 8'h89);
    wait_idle(n8, n16); rres(r8, r16); rd(4'h5, s8, s16);
    chk("divz_lat", n8, 0); chk("divz_r", r8, 32'h64FF); chk("divz_flag", s8[4], 1);

    // Overrun: write A mid-run, snapshot operand still used
    setab(16'd12, 16'd10); do_op(4'd7);
    repeat (2) @(negedge clk);
    wr(4'h0, 8'h11);
    wait_idle(n8, n16); rres(r8, r16); rd(4'h5, s8, s16);
    chk("ovr_r", r8, 32'h0078); chk("ovr_st", s8, 8'h42);
    rd(4'h0, s8, s16); chk("ovr_a_kept", s8, 8'h0C);
    wr(4'h5, 8'h40); rd(4'h5, s8, s16); chk("ovr_w1c", s8, 8'h02);

    // W1C of done on the completion edge: completion wins
    setab(16'd3, 16'd4); do_op(4'd7);
    repeat (7) @(negedge clk);
    wr(4'h5, 8'h02); rd(4'h5, s8, s16);
    chk("done_race", s8 & 8'h03, 8'h02);
    wr(4'h5, 8'h02); rd(4'h5, s8, s16);
    chk("done_w1c", s8[1], 0);

    // MAC accumulation, then reset mid-operation
    pulse_rst();
    setab(16'h10, 16'h10); wr(4'h4, 8'h88);
    wait_idle(n8, n16); rres(r8, r16); chk("mac1", r8, 32'h0100);
    wr(4'h4, 8'h88);
    wait_idle(n8, n16); rres(r8, r16); chk("mac2", r8, 32'h0200);
    wr(4'h4, 8'h88);
    repeat (2) @(negedge clk);
    pulse_rst();
    rres(r8, r16); rd(4'h5, s8, s16);
    chk("mac_rst_r", r8, 32'h0); chk("mac_rst_st", s8, 8'h0); chk("mac_rst_uo", uo8, 8'h0);

    // Register map edges
    wr(4'h1, 8'hAB); rd(4'h1, s8, s16);
    chk("hi_w8", s8, 8'h00); chk("hi_w16", s16, 8'hAB);
    rd(4'hA, s8, s16); chk("unmapped", {s8, s16}, 16'h0);
    wr(4'h4, 8'h03); rd(4'h4, s8, s16); chk("ctrl_rd", s8, 8'h03);
    rd(4'h5, s8, s16); chk("ctrl_nostart", s8, 8'h00);

    // W=16 full-scale multiply, then an illegal opcode
    setab(16'hFFFF, 16'hFFFF); do_op(4'd7);
    wait_idle(n8, n16); rres(r8, r16);
    chk("w16_lat", n16, 16); chk("w16_mul", r16, 32'hFFFE_0001);
    chk("w8_lat", n8, 8); chk("w8_mul", r8, 32'hFE01);
    wr(4'h4, 8'h8C);
    wait_idle(n8, n16); rres(r8, r16); rd(4'h5, s8, s16);
    chk("ill_r", r16, 32'hFFFE_0001); chk("ill_st", s16 & 8'hE3, 8'h22);

    foreach (tbl[i]) begin
      setab({8'h0, tbl[i].a}, {8'h0, tbl[i].b}); do_op(tbl[i].op);
      wait_idle(n8, n16); rres(r8, r16); rd(4'h5, s8, s16);
      chk($sformatf("vec%0d_r", i), r8[15:0], tbl[i].r);
      chk($sformatf("vec%0d_st", i), s8 & tbl[i].msk, tbl[i].st & tbl[i].msk);
    end

    pulse_rst();
    mr8 = '0; mr16 = '0;
    for (int it = 0; it < 60; it++) begin
      ra = 16'($urandom); rb = 16'($urandom); rop = 4'($urandom_range(0, 15));
      if (rop == 4'd5 || rop == 4'd6) rb = 16'($urandom_range(0, 20));
      if (rop == 4'd9 && $urandom_range(0, 3) == 0) rb = '0;
      setab(ra, rb); do_op(rop);
      wait_idle(n8, n16); rres(r8, r16); rd(4'h5, s8, s16);
      model(8, rop, ra, rb, mr8, e8, es8, m8, l8);
      model(16, rop, ra, rb, mr16, e16, es16, m16, l16);
      chk($sformatf("rnd%0d_op%0d_r8", it, rop), r8, e8);
      chk($sformatf("rnd%0d_op%0d_st8", it, rop), s8 & m8, es8 & m8);
      chk($sformatf("rnd%0d_op%0d_lat8", it, rop), n8, l8);
      chk($sformatf("rnd%0d_op%0d_r16", it, rop), r16, e16);
      chk($sformatf("rnd%0d_op%0d_st16", it, rop), s16 & m16, es16 & m16);
      chk($sformatf("rnd%0d_op%0d_lat16", it, rop), n16, l16);
      mr8 = e8; mr16 = e16;
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
